// File: rtl/count_seq_checker.sv
// Consumer-side checker for a wrapping LO..HI counter stream: locks onto the
// sequence, flags mismatches and wraps, and keeps a saturating error count.
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LO       = 1,
    parameter int HI       = 10,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_q_i,
    input  logic             in_restart_i,
    output logic             locked_o,
    output logic [WIDTH-1:0] expected_o,
    output logic             err_pulse_o,
    output logic             wrap_pulse_o,
    output logic [ERR_W-1:0] err_count_o
);

    // state     | meaning
    // ST_HUNT   | no reference; waiting for any in-range value to seed from
    // ST_SYNC   | seeded; counting consecutive in-sequence beats
    // ST_LOCKED | LOCK_CNT good beats seen; mismatches are reported
    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int               RUN_W   = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] LO_V    = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_V    = WIDTH'(HI);
    localparam logic [RUN_W-1:0] LOCK_V  = RUN_W'(LOCK_CNT);
    localparam logic [1:0]       SEED_ST = (LOCK_CNT == 1) ? ST_LOCKED : ST_SYNC;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic             in_range;
    logic             match;
    logic [RUN_W-1:0] run_inc;

    function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] x);
        return (x == HI_V) ? LO_V : WIDTH'(x + 1'b1);
    endfunction

    assign in_range = (in_q_i >= LO_V) && (in_q_i <= HI_V);
    assign match    = (in_q_i == exp_q);
    assign run_inc  = RUN_W'(run_q + 1'b1);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        run_d   = run_q;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        if (in_valid_i) begin
            if (in_restart_i && (in_q_i == LO_V)) begin
                // Source restarted cleanly: reseed without penalty, keep lock if held
                exp_d   = next_val(LO_V);
                run_d   = RUN_W'(1);
                state_d = (state_q == ST_LOCKED) ? ST_LOCKED : SEED_ST;
            end else begin
                case (state_q)
                    ST_SYNC: begin
                        if (match) begin
                            run_d = run_inc;
                            exp_d = next_val(in_q_i);
                            if (run_inc >= LOCK_V) state_d = ST_LOCKED;
                        end else if (in_range) begin
                            exp_d   = next_val(in_q_i);
                            run_d   = RUN_W'(1);
                            state_d = SEED_ST;
                        end else begin
                            state_d = ST_HUNT;
                        end
                    end
                    ST_LOCKED: begin
                        if (match) begin
                            exp_d  = next_val(in_q_i);
                            wrap_d = (in_q_i == HI_V);
                        end else begin
                            err_d = 1'b1;
                            if (cnt_q != ERR_MAX) cnt_d = cnt_q + 1'b1;
                            if (in_range) begin
                                exp_d   = next_val(in_q_i);
                                run_d   = RUN_W'(1);
                                state_d = SEED_ST;
                            end else begin
                                state_d = ST_HUNT;
                            end
                        end
                    end
                    default: begin
                        if (in_range) begin
                            exp_d   = next_val(in_q_i);
                            run_d   = RUN_W'(1);
                            state_d = SEED_ST;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HUNT;
            exp_q   <= LO_V;
            run_q   <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            run_q   <= run_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign locked_o     = (state_q == ST_LOCKED);
    assign expected_o   = exp_q;
    assign err_pulse_o  = err_q;
    assign wrap_pulse_o = wrap_q;
    assign err_count_o  = cnt_q;

endmodule
